// File: rtl/mill_pkg.sv
// Shared types and constants for the Miller receive frame controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mill_pkg;

  // Frame controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RX   = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  // Error codes reported on out_err
  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_PARITY   = 3'd1,
    ERR_TIMEOUT  = 3'd2,
    ERR_OVERFLOW = 3'd3,
    ERR_FRAMING  = 3'd4
  } err_t;

  // Bit timing: one ETU is 32 clocks; the receiver gives up after two silent ETUs
  localparam int ETU_CLKS     = 32;
  localparam int TIMEOUT_CLKS = 2 * ETU_CLKS;
  localparam int TMR_W        = $clog2(TIMEOUT_CLKS);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CLKS - 1);

  // Output FIFO entry: received byte plus count of valid bits (0 means all 8)
  typedef struct packed {
    logic [7:0] data;
    logic [2:0] nbits;
  } fifo_ent_t;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_W     = $bits(fifo_ent_t);

endpackage

// File: rtl/mill_byte_fifo.sv
// Two-entry byte FIFO between the frame controller and the host, with flush.
// Latency: a pushed entry is visible on pop_vld the clock after the push.
// Backpressure: full when two entries held; a push while full is accepted only with a same-clock pop.
module mill_byte_fifo
  import mill_pkg::*;
#(
  parameter int W = FIFO_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  output logic         full,
  output logic         pop_vld,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat
);

  logic [W-1:0] mem [FIFO_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic         wr_en;
  logic         rd_en;

  assign full    = (cnt == 2'd2);
  assign pop_vld = (cnt != 2'd0);
  assign pop_dat = mem[rd_ptr];
  assign rd_en   = pop_vld & pop_rdy;
  // A full FIFO still takes a push when the head leaves in the same clock
  assign wr_en   = push_vld & (~full | rd_en);

  // Storage, pointers and occupancy; flush empties without touching storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (rd_en) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, wr_en} - {1'b0, rd_en};
    end
  end

endmodule

// File: rtl/mill_rx_frame_ctrl.sv
// Miller receive frame controller: assembles decoded bits into bytes and frames them. Optional MILL_PARITY_CHECK_EN enables odd-parity checking.
// Latency: a byte is offered on out_byte_valid 1 clk after its parity strobe (or after EOF for a short frame).
// Backpressure: in_byte_ready pops a 2-entry FIFO; a push into a full FIFO without a pop raises overflow.
module mill_rx_frame_ctrl
  import mill_pkg::*;
(
  input  logic       clk,
  input  logic       in_PoR,
  input  logic       in_enable,
  input  logic       in_sof,
  input  logic       in_eof,
  input  logic       in_bit,
  input  logic       in_bit_stb,
  output logic       out_demod_en,
  output logic [7:0] out_byte,
  output logic       out_byte_valid,
  input  logic       in_byte_ready,
  output logic [2:0] out_nbits,
  output logic       out_frame_done,
  output logic [2:0] out_err,
  output logic       out_busy
);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d, cnt_upd;
  logic [8:0]       sr_q, sr_d, sr_upd;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  err_t             err_q, err_d, code;
  logic             seen_q, seen_d, seen_upd;
  logic             run_q;
  logic             push_req, push, flush, go_done, parity_ok;
  fifo_ent_t        push_ent, head;
  logic             fifo_vld, fifo_full, pop;

  assign pop = fifo_vld & in_byte_ready;

  mill_byte_fifo #(.W(FIFO_W)) u_fifo (
    .clk      (clk),
    .rst_n    (in_PoR),
    .flush    (flush),
    .push_vld (push),
    .push_dat (push_ent),
    .full     (fifo_full),
    .pop_vld  (fifo_vld),
    .pop_rdy  (in_byte_ready),
    .pop_dat  (head)
  );

  // Demod enable follows the host, but is held low until the first clock after reset
  assign out_demod_en   = in_enable & run_q;
  assign out_byte_valid = fifo_vld;
  assign out_byte       = fifo_vld ? head.data  : 8'd0;
  assign out_nbits      = fifo_vld ? head.nbits : 3'd0;
  assign out_frame_done = (state_q == ST_DONE);
  assign out_err        = err_q;
  assign out_busy       = (state_q == ST_RX) | fifo_vld;

  // State and datapath registers
  always_ff @(posedge clk or negedge in_PoR) begin
    if (!in_PoR) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      sr_q    <= 9'd0;
      tmr_q   <= '0;
      err_q   <= ERR_NONE;
      seen_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
      seen_q  <= seen_d;
      run_q   <= 1'b1;
    end
  end

  // Next state: bit strobe is applied first, then EOF is judged on the updated count
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    tmr_d     = tmr_q;
    err_d     = err_q;
    seen_d    = seen_q;
    push      = 1'b0;
    push_req  = 1'b0;
    push_ent  = '0;
    flush     = 1'b0;
    go_done   = 1'b0;
    parity_ok = 1'b1;
    code      = ERR_NONE;
    sr_upd    = in_bit_stb ? {in_bit, sr_q[8:1]} : sr_q;
    cnt_upd   = cnt_q;
    seen_upd  = seen_q;

    case (state_q)
      ST_IDLE: begin
        if (in_sof && in_enable) begin
          state_d = ST_RX;
          cnt_d   = 4'd0;
          sr_d    = 9'd0;
          tmr_d   = '0;
          err_d   = ERR_NONE;
          seen_d  = 1'b0;
        end
      end

      ST_RX: begin
        if (!in_enable) begin
          // Host abort: drop everything, no error reported
          state_d = ST_IDLE;
          flush   = 1'b1;
        end else begin
          if (in_bit_stb) begin
            if (cnt_q == 4'd8) begin
              cnt_upd  = 4'd0;
              seen_upd = 1'b1;
`ifdef MILL_PARITY_CHECK_EN
              parity_ok = ^sr_upd;
`else
              parity_ok = 1'b1;
`endif
              if (parity_ok) begin
                push_req       = 1'b1;
                push_ent.data  = sr_upd[7:0];
                push_ent.nbits = 3'd0;
              end else begin
                code = ERR_PARITY;
              end
            end else begin
              cnt_upd = cnt_q + 4'd1;
            end
          end

          if (code == ERR_NONE) begin
            if (in_eof) begin
              if (cnt_upd == 4'd0 && seen_upd) begin
                go_done = 1'b1;
              end else if (cnt_upd == 4'd7 && !seen_upd) begin
                // Short frame: the 7 bits sit in the top of the shift register
                go_done        = 1'b1;
                push_req       = 1'b1;
                push_ent.data  = {1'b0, sr_upd[8:2]};
                push_ent.nbits = 3'd7;
              end else begin
                code = ERR_FRAMING;
              end
            end else if (!in_bit_stb) begin
              if (tmr_q == TMR_LAST) code = ERR_TIMEOUT;
              else                   tmr_d = tmr_q + 1'b1;
            end else begin
              tmr_d = '0;
            end
          end

          if (push_req && fifo_full && !pop) code = ERR_OVERFLOW;

          if (code != ERR_NONE) begin
            state_d = ST_ERR;
            err_d   = code;
            flush   = 1'b1;
          end else begin
            push    = push_req;
            cnt_d   = cnt_upd;
            seen_d  = seen_upd;
            sr_d    = push_req ? 9'd0 : sr_upd;
            if (go_done) state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        // FIFO keeps its content so the host can drain the frame
        state_d = ST_IDLE;
      end

      ST_ERR: begin
        flush   = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mill_rx_frame_ctrl.sv
module tb_mill_rx_frame_ctrl;

  logic       clk = 1'b0;
  logic       in_PoR, in_enable, in_sof, in_eof, in_bit, in_bit_stb, in_byte_ready;
  logic       out_demod_en, out_byte_valid, out_frame_done, out_busy;
  logic [7:0] out_byte;
  logic [2:0] out_nbits, out_err;

  int n_vec = 0;
  int n_mis = 0;

`ifdef MILL_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic [10:0] got[$];
  logic [10:0] exp_q[$];
  int          done_cnt = 0;

  always #5 clk = ~clk;

  mill_rx_frame_ctrl dut (
    .clk            (clk),
    .in_PoR         (in_PoR),
    .in_enable      (in_enable),
    .in_sof         (in_sof),
    .in_eof         (in_eof),
    .in_bit         (in_bit),
    .in_bit_stb     (in_bit_stb),
    .out_demod_en   (out_demod_en),
    .out_byte       (out_byte),
    .out_byte_valid (out_byte_valid),
    .in_byte_ready  (in_byte_ready),
    .out_nbits      (out_nbits),
    .out_frame_done (out_frame_done),
    .out_err        (out_err),
    .out_busy       (out_busy)
  );

  // Host-side monitor: record every accepted byte and every done pulse
  always @(negedge clk) begin
    if (in_PoR === 1'b1 && out_byte_valid === 1'b1 && in_byte_ready === 1'b1)
      got.push_back({out_nbits, out_byte});
    if (out_frame_done === 1'b1) done_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running, required finish");
    $fatal(1);
  end

  typedef struct {
    logic       sof, eof, stb, b, en, rdy;
    logic       vld;
    logic [7:0] byt;
    logic [2:0] nb;
    logic       done;
    logic [2:0] err;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic sof, input logic eof, input logic stb, input logic b,
                              input logic en, input logic rdy, input logic vld,
                              input logic [7:0] byt, input logic [2:0] nb, input logic done,
                              input logic [2:0] err, input logic busy);
    vec_t v;
    v.sof = sof; v.eof = eof; v.stb = stb; v.b = b; v.en = en; v.rdy = rdy;
    v.vld = vld; v.byt = byt; v.nb = nb; v.done = done; v.err = err; v.busy = busy;
    return v;
  endfunction

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

  function automatic logic [31:0] outs();
    return {14'd0, out_demod_en, out_byte_valid, out_byte, out_nbits, out_frame_done, out_err, out_busy};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_got(input string name);
    chk({name, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got.size()) chk($sformatf("%s_b%0d", name, i), {21'd0, got[i]}, {21'd0, exp_q[i]});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic do_sof();
    in_sof = 1'b1; step(); in_sof = 1'b0;
  endtask

  task automatic do_eof();
    in_eof = 1'b1; step(); in_eof = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    in_bit = b; in_bit_stb = 1'b1; step(); in_bit_stb = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] d, input int n);
    for (int k = 0; k < n; k++) send_bit(d[k]);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic p);
    send_data(d, 8);
    send_bit(p);
  endtask

  // Random frame against a frame-level model: groups of 9 bits, then EOF rules
  task automatic rand_frame(input int idx);
    int unsigned nb, sel, extra, gap;
    logic [7:0]  d;
    logic [8:0]  xbits;
    logic        bits[$];
    logic [7:0]  dat[$];
    logic        bads[$];
    bit          merge, stop;
    logic [2:0]  exp_err;
    int          exp_done;

    nb    = $urandom_range(0, 3);
    sel   = $urandom_range(0, 3);
    extra = (sel == 0) ? 0 : (sel == 1) ? 7 : $urandom_range(0, 8);
    for (int i = 0; i < int'(nb); i++) begin
      d = 8'($urandom_range(0, 255));
      dat.push_back(d);
      bads.push_back($urandom_range(0, 5) == 0);
      for (int k = 0; k < 8; k++) bits.push_back(d[k]);
      bits.push_back(odd_par(d) ^ bads[i]);
    end
    xbits = 9'($urandom_range(0, 511));
    for (int k = 0; k < int'(extra); k++) bits.push_back(xbits[k]);

    exp_q.delete();
    exp_err  = 3'd0;
    exp_done = 0;
    stop     = 1'b0;
    for (int i = 0; i < int'(nb); i++) begin
      if (!stop) begin
        if (bads[i] && PAR_EN) begin
          exp_err = 3'd1;
          stop    = 1'b1;
        end else begin
          exp_q.push_back({3'd0, dat[i]});
        end
      end
    end
    if (!stop) begin
      if (extra == 0 && nb > 0) begin
        exp_done = 1;
      end else if (extra == 7 && nb == 0) begin
        exp_q.push_back({3'd7, 1'b0, xbits[6:0]});
        exp_done = 1;
      end else begin
        exp_err = 3'd4;
      end
    end

    got.delete();
    done_cnt = 0;
    do_sof();
    merge = (bits.size() > 0) && ($urandom_range(0, 1) == 1);
    for (int i = 0; i < bits.size(); i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) step();
      in_bit     = bits[i];
      in_bit_stb = 1'b1;
      if (merge && i == bits.size() - 1) in_eof = 1'b1;
      step();
      in_bit_stb = 1'b0;
      in_eof     = 1'b0;
    end
    if (!merge) begin
      repeat ($urandom_range(0, 3)) step();
      do_eof();
    end
    idle(4);

    chk_got($sformatf("rnd%0d", idx));
    chk($sformatf("rnd%0d_done", idx), done_cnt, exp_done);
    chk($sformatf("rnd%0d_err", idx), out_err, exp_err);
  endtask

  logic [7:0] b53 = 8'h53;
  logic [7:0] b26 = 8'h26;

  initial begin
    in_PoR = 1'b0; in_enable = 1'b1; in_sof = 1'b0; in_eof = 1'b0;
    in_bit = 1'b0; in_bit_stb = 1'b0; in_byte_ready = 1'b1;

    // Table: full byte 0x53 with good parity, then a 7-bit short frame 0x26 with EOF on the last bit
    tbl.push_back(mk(1,0,0,0,1,1, 0,8'h00,3'd0, 0,3'd0,1));
    for (int k = 0; k < 8; k++) tbl.push_back(mk(0,0,1,b53[k],1,1, 0,8'h00,3'd0, 0,3'd0,1));
    tbl.push_back(mk(0,0,1,1,1,1, 1,8'h53,3'd0, 0,3'd0,1));
    tbl.push_back(mk(0,1,0,0,1,1, 0,8'h00,3'd0, 1,3'd0,0));
    tbl.push_back(mk(0,0,0,0,1,1, 0,8'h00,3'd0, 0,3'd0,0));
    tbl.push_back(mk(1,0,0,0,1,1, 0,8'h00,3'd0, 0,3'd0,1));
    for (int k = 0; k < 6; k++) tbl.push_back(mk(0,0,1,b26[k],1,1, 0,8'h00,3'd0, 0,3'd0,1));
    tbl.push_back(mk(0,1,1,b26[6],1,1, 1,8'h26,3'd7, 1,3'd0,1));
    tbl.push_back(mk(0,0,0,0,1,1, 0,8'h00,3'd0, 0,3'd0,0));

    // Reset: everything low, including demod enable, until the first edge after release
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", outs(), 32'd0);
    in_PoR = 1'b1;
    #1;
    chk("release_pre_edge", outs(), 32'd0);
    step();
    chk("demod_en_after_edge", out_demod_en, 1);
    chk("idle_busy", out_busy, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      logic [31:0] act, exp;
      in_sof = tbl[i].sof; in_eof = tbl[i].eof; in_bit_stb = tbl[i].stb;
      in_bit = tbl[i].b; in_enable = tbl[i].en; in_byte_ready = tbl[i].rdy;
      step();
      exp = {15'd0, tbl[i].vld, tbl[i].vld ? tbl[i].byt : 8'h00, tbl[i].vld ? tbl[i].nb : 3'd0,
             tbl[i].done, tbl[i].err, tbl[i].busy};
      act = {15'd0, out_byte_valid, tbl[i].vld ? out_byte : 8'h00, tbl[i].vld ? out_nbits : 3'd0,
             out_frame_done, out_err, out_busy};
      chk($sformatf("tbl%0d", i), act, exp);
    end
    in_sof = 0; in_eof = 0; in_bit_stb = 0; in_enable = 1; in_byte_ready = 1;
    idle(2);

    // Bad parity on 0x53
    got.delete(); done_cnt = 0;
    do_sof();
    send_byte(8'h53, 1'b0);
    if (PAR_EN) begin
      chk("par_err", out_err, 1);
      chk("par_novalid", out_byte_valid, 0);
    end else begin
      chk("par_off_valid", {out_byte_valid, out_byte}, {1'b1, 8'h53});
      chk("par_off_err", out_err, 0);
    end
    do_eof();
    idle(2);
    exp_q.delete();
    if (!PAR_EN) exp_q.push_back({3'd0, 8'h53});
    chk_got("par");
    chk("par_done", done_cnt, PAR_EN ? 0 : 1);

    // Overflow: three bytes with the host stalled
    in_byte_ready = 1'b0;
    do_sof();
    send_byte(8'h01, odd_par(8'h01));
    send_byte(8'h02, odd_par(8'h02));
    chk("ovf_two_held", {out_err, out_byte_valid, out_busy}, {3'd0, 1'b1, 1'b1});
    send_byte(8'h03, odd_par(8'h03));
    chk("ovf_err", {out_err, out_byte_valid, out_busy}, {3'd3, 1'b0, 1'b0});
    step();
    chk("ovf_hold", {out_err, out_byte_valid, out_busy}, {3'd3, 1'b0, 1'b0});
    idle(1);

    // Push into a full FIFO with a simultaneous pop is accepted
    do_sof();
    chk("sof_clears_err", out_err, 0);
    send_byte(8'hC1, odd_par(8'hC1));
    send_byte(8'h7E, odd_par(8'h7E));
    send_data(8'h9D, 8);
    got.delete(); done_cnt = 0;
    in_byte_ready = 1'b1;
    send_bit(odd_par(8'h9D));
    chk("full_pushpop", {out_err, out_byte_valid}, {3'd0, 1'b1});
    idle(2);
    do_eof();
    idle(2);
    exp_q.delete();
    exp_q.push_back({3'd0, 8'hC1}); exp_q.push_back({3'd0, 8'h7E}); exp_q.push_back({3'd0, 8'h9D});
    chk_got("pushpop");
    chk("pushpop_done", done_cnt, 1);

    // Timeout: 64 silent clocks after the last strobe
    do_sof();
    send_data(8'h05, 3);
    idle(63);
    chk("tmo_before", {out_err, out_busy}, {3'd0, 1'b1});
    step();
    chk("tmo_at_64", {out_err, out_busy}, {3'd2, 1'b0});
    step();
    chk("tmo_idle", {out_err, out_busy}, {3'd2, 1'b0});

    // Asynchronous reset mid-byte
    do_sof();
    send_data(8'hFF, 4);
    in_PoR = 1'b0;
    #1;
    chk("arst_outs", outs(), 32'd0);
    idle(2);
    in_PoR = 1'b1;
    step();
    got.delete(); done_cnt = 0;
    do_sof();
    send_data(8'hA5, 4);
    do_sof();
    for (int k = 4; k < 8; k++) send_bit(b53[0] ^ b53[0] ^ (8'hA5 >> k) & 8'h01);
    send_bit(odd_par(8'hA5));
    do_eof();
    idle(2);
    exp_q.delete();
    exp_q.push_back({3'd0, 8'hA5});
    chk_got("post_rst");
    chk("post_rst_done", {done_cnt[7:0], 5'd0, out_err}, {8'd1, 5'd0, 3'd0});

    // Host drops enable mid-frame with a byte still queued
    in_byte_ready = 1'b0;
    do_sof();
    send_byte(8'h11, odd_par(8'h11));
    chk("abort_queued", out_byte_valid, 1);
    send_data(8'h07, 3);
    in_enable = 1'b0;
    step();
    chk("abort_outs", outs(), 32'd0);
    in_enable = 1'b1; in_byte_ready = 1'b1;
    step();
    got.delete(); done_cnt = 0;
    do_sof();
    send_byte(8'h3C, odd_par(8'h3C));
    do_eof();
    idle(2);
    exp_q.delete();
    exp_q.push_back({3'd0, 8'h3C});
    chk_got("post_abort");
    chk("post_abort_err", out_err, 0);

    for (int f = 0; f < 40; f++) begin
      rand_frame(f);
      idle(2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/mill_rx_frame_ctrl.md
MILL_RX_FRAME_CTRL -- requirements
Module: mill_rx_frame_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, 3.39 MHz (32 clk per ETU).
REQ-002 SHALL have ports: in_PoR  in  1  reset, asynchronous and active-low (0 = reset, 1 = run).
REQ-003 SHALL have ports: in_enable  in  1  receiver enable from host.
REQ-004 SHALL have ports: in_sof / in_eof  in  1 each  single-clk pulses from the Miller decoder.
REQ-005 SHALL have ports: in_bit  in  1  decoded bit value; in_bit_stb  in  1  single-clk strobe, in_bit valid.
REQ-006 SHALL have ports: out_demod_en  out  1  enable to the Miller decoder.
REQ-007 SHALL have ports: out_byte  out  8  received data; out_byte_valid  out  1; in_byte_ready  in  1.
REQ-008 SHALL have ports: out_nbits  out  3  valid bits in out_byte (0 = 8 bits, 7 = short frame).
REQ-009 SHALL have ports: out_frame_done  out  1  single-clk pulse; out_err  out  3  error code; out_busy  out  1.

Function
REQ-010 SHALL implement states IDLE, RX, DONE, ERR.
REQ-011 SHALL drive out_demod_en = in_enable in every state.
REQ-012 IDLE: in_sof with in_enable=1 SHALL enter RX, clear bit count, clear timeout counter and set out_err=0.
REQ-013 RX: each in_bit_stb SHALL shift in_bit LSB-first into a 9-bit register and increment the bit count (0..8).
REQ-014 When the 9th bit (parity) arrives, the block SHALL push data bits [7:0] into the output FIFO with out_nbits=0, then reset the bit count to 0.
REQ-015 out_byte_valid SHALL assert 1 clk after the parity strobe.
REQ-016 The output FIFO SHALL be 2 entries deep; a byte is popped when out_byte_valid and in_byte_ready are both 1.
REQ-017 A push while the FIFO is full SHALL enter ERR with out_err=3 (overflow).
REQ-018 A push and pop in the same clk while the FIFO is full SHALL be accepted without error.
REQ-019 in_eof with bit count 0 and at least one byte received SHALL enter DONE.
REQ-020 in_eof with bit count 7 and zero bytes received SHALL push the 7 bits as a short frame (out_nbits=7) and enter DONE.
REQ-021 Any other in_eof SHALL enter ERR with out_err=4 (framing).
REQ-022 If in_bit_stb and in_eof occur in the same clk, the bit SHALL be processed first and EOF evaluated with the updated count.
REQ-023 Timeout: 64 clk in RX without an in_bit_stb or in_eof SHALL enter ERR with out_err=2.
REQ-024 DONE SHALL pulse out_frame_done for 1 clk and return to IDLE; the FIFO content SHALL remain for draining.
REQ-025 ERR SHALL flush the FIFO, hold out_err until the next accepted in_sof, and return to IDLE next clk.
REQ-026 in_enable falling in RX SHALL abort to IDLE, flush the FIFO and leave out_err=0.
REQ-027 in_sof in RX SHALL be ignored.
REQ-028 out_busy SHALL be 1 in RX, or whenever the FIFO is non-empty.

Reset
REQ-029 in_PoR=0 SHALL asynchronously force IDLE, empty the FIFO and drive every output 0.
REQ-030 Outputs SHALL stay 0 until the first clk edge after in_PoR returns to 1.
REQ-031 Reset mid-frame SHALL discard all partial data.

Configuration
REQ-032 Macro MILL_PARITY_CHECK_EN SHALL control parity checking.
REQ-033 With MILL_PARITY_CHECK_EN defined, the 9-bit group SHALL have odd parity; otherwise the block SHALL enter ERR with out_err=1 and push nothing.
REQ-034 With MILL_PARITY_CHECK_EN undefined, the parity bit SHALL be discarded unchecked and out_err=1 SHALL never occur.

Structure
REQ-035 A shared package (mill_pkg) SHALL hold the state encoding, the error codes (0 none, 1 parity, 2 timeout, 3 overflow, 4 framing), ETU_CLKS=32 and TIMEOUT_CLKS=64.
REQ-036 The FIFO SHALL be a sub-module, mill_byte_fifo (depth 2, width 11: byte + nbits).

Verification
REQ-037 SOF, 9 bits 0x53 + parity 1 with ready=1, EOF -> out_byte=0x53, out_nbits=0, out_frame_done pulse, out_err=0.
REQ-038 SOF, 7 bits 0x26, EOF -> out_byte=0x26, out_nbits=7, out_frame_done pulse.
REQ-039 Byte 0x53 with parity bit 0, macro defined -> out_err=1, no out_byte_valid; macro undefined -> 0x53 delivered.
REQ-040 SOF, 3 bits, then no strobe for 64 clk -> out_err=2 at clk 64, state IDLE.
REQ-041 Three bytes with in_byte_ready=0 -> out_err=3 on the third push, FIFO empty.
REQ-042 in_PoR=0 mid-byte, then an in_enable drop mid-frame -> all outputs 0, no error, next SOF receives normally.
